if_prefetch: RTL

- Instruction fetch front end that sits directly upstream of the IF/ID pipeline register.
- Replaces the bare pc_reg-to-instruction-port path.
- Issues sequential fetch requests to the instruction memory port over a req/gnt/rvalid handshake and buffers returned words in a small FIFO.
- Presents one instruction per cycle to if_id.
- Honours the hazard unit's stall and a flush/redirect, and discards stale in-flight responses.

---
 rtl/if_prefetch.sv | 128 ++++++++++++
 1 files changed

// File: rtl/if_prefetch.sv
// if_prefetch: sequential instruction fetch front end with a small in-order response FIFO feeding IF/ID.
// Defining IF_PREFETCH_PERF_EN adds the perf_starve_o / perf_discard_o saturating counters.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module if_prefetch #(
  parameter int                     FIFO_DEPTH = 4,
  parameter logic [`ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   imem_req_o,
  output logic [`ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [`DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic [`ADDR_WIDTH-1:0] redirect_addr_i,
  output logic                   inst_valid_o,
  output logic [`DATA_WIDTH-1:0] inst_o,
  output logic [`ADDR_WIDTH-1:0] inst_addr_o
`ifdef IF_PREFETCH_PERF_EN
  ,
  output logic [31:0]            perf_starve_o,
  output logic [31:0]            perf_discard_o
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_N = CW'(FIFO_DEPTH);

  logic [`DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]          rd_ptr, wr_ptr;
  logic [CW-1:0]          count, outstanding, discard_cnt, flush_outstanding;
  logic [`ADDR_WIDTH-1:0] fetch_pc, out_pc, redirect_aligned;
  logic [CW:0]            credit_used;
  logic                   fire, resp_drop, resp_keep, full, push, pop;
  logic                   unused_redirect_lsb;

  // Credits cover both buffered words and words still in flight, so a response always has a slot.
  assign credit_used = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_o  = !rst_i && !flush_i && (credit_used < DEPTH_C);
  assign imem_addr_o = fetch_pc;
  assign fire        = imem_req_o & imem_gnt_i;

  assign resp_drop = imem_rvalid_i & (discard_cnt != '0);
  assign resp_keep = imem_rvalid_i & (discard_cnt == '0) & !flush_i;
  assign full      = (count == DEPTH_N);

  assign inst_valid_o = (count != '0);
  assign pop          = inst_valid_o & !stall_i & !flush_i;
  assign push         = resp_keep & (!full | pop);
  assign inst_o       = mem[rd_ptr];
  assign inst_addr_o  = out_pc;

  assign redirect_aligned    = {redirect_addr_i[`ADDR_WIDTH-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_addr_i[1:0];
  assign flush_outstanding   = outstanding - CW'(imem_rvalid_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc    <= RESET_PC;
      out_pc      <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard_cnt <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (flush_i) begin
      // Everything still in flight after this edge belongs to the old stream.
      fetch_pc    <= redirect_aligned;
      out_pc      <= redirect_aligned;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      outstanding <= flush_outstanding;
      discard_cnt <= flush_outstanding;
    end else begin
      if (fire) fetch_pc <= fetch_pc + `ADDR_WIDTH'(4);
      outstanding <= outstanding + CW'(fire) - CW'(imem_rvalid_i);
      if (resp_drop) discard_cnt <= discard_cnt - CW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        out_pc <= out_pc + `ADDR_WIDTH'(4);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= imem_rdata_i;
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(resp_keep && full && !pop));

`ifdef IF_PREFETCH_PERF_EN
  logic [CW:0] discard_inc;
  logic [32:0] discard_sum;

  // Flushed FIFO contents count as discarded work alongside dropped stale responses.
  assign discard_inc = (CW+1)'(resp_drop) + (flush_i ? {1'b0, count} : '0);
  assign discard_sum = {1'b0, perf_discard_o} + 33'(discard_inc);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_starve_o  <= '0;
      perf_discard_o <= '0;
    end else begin
      if (!inst_valid_o && !stall_i && !flush_i && (perf_starve_o != 32'hFFFF_FFFF))
        perf_starve_o <= perf_starve_o + 32'd1;
      perf_discard_o <= discard_sum[32] ? 32'hFFFF_FFFF : discard_sum[31:0];
    end
  end
`endif

endmodule
